// File: rtl/sprite_arbiter.sv
// Sprite pixel arbiter with a sequential bounding-box collision checker.
// The draw path and the collision FSM run independently from a single clock.
module sprite_arbiter #(
    parameter int NUM_OBJ = 3,
    parameter int SIZE    = 10,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int CW      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_OBJ-1:0]    obj_req,
    input  logic [NUM_OBJ-1:0]    obj_en,
    input  logic [NUM_OBJ*XW-1:0] obj_x,
    input  logic [NUM_OBJ*YW-1:0] obj_y,
    input  logic [NUM_OBJ*CW-1:0] obj_colour,
    input  logic                  heli_req,
    input  logic [XW-1:0]         heli_x,
    input  logic [YW-1:0]         heli_y,
    input  logic [CW-1:0]         heli_colour,
    input  logic                  check,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [CW-1:0]         colour,
    output logic                  plot,
    output logic                  collision,
    output logic                  done_check,
    output logic                  busy
);

    localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [XW:0] SIZE_X = (XW+1)'(SIZE);
    localparam logic [YW:0] SIZE_Y = (YW+1)'(SIZE);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic [CW-1:0] win_colour;
    logic          win_plot;

    logic [XW-1:0]      snap_obj_x [NUM_OBJ];
    logic [YW-1:0]      snap_obj_y [NUM_OBJ];
    logic [NUM_OBJ-1:0] snap_en;
    logic [XW-1:0]      snap_heli_x;
    logic [YW-1:0]      snap_heli_y;
    logic [IW-1:0]      idx;

    logic          accept;
    logic          last;
    logic          overlap;
    logic [XW:0]   dx_raw;
    logic [XW:0]   dx_abs;
    logic [YW:0]   dy_raw;
    logic [YW:0]   dy_abs;

    // Descending scan so the lowest-numbered requesting obstacle overrides the rest.
    always_comb begin
        win_plot   = heli_req;
        win_x      = heli_req ? heli_x : '0;
        win_y      = heli_req ? heli_y : '0;
        win_colour = heli_req ? heli_colour : '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (obj_req[i]) begin
                win_plot   = 1'b1;
                win_x      = obj_x[i*XW +: XW];
                win_y      = obj_y[i*YW +: YW];
                win_colour = obj_colour[i*CW +: CW];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else begin
            x      <= win_x;
            y      <= win_y;
            colour <= win_colour;
            plot   <= win_plot;
        end
    end

    assign accept = (state == IDLE) && check;
    assign last   = (idx == IW'(NUM_OBJ - 1));

    // One extra bit keeps the difference signed, so coordinates near 0 or max never wrap.
    always_comb begin
        dx_raw  = {1'b0, snap_heli_x} - {1'b0, snap_obj_x[idx]};
        dy_raw  = {1'b0, snap_heli_y} - {1'b0, snap_obj_y[idx]};
        dx_abs  = dx_raw[XW] ? -dx_raw : dx_raw;
        dy_abs  = dy_raw[YW] ? -dy_raw : dy_raw;
        overlap = snap_en[idx] && (dx_abs < SIZE_X) && (dy_abs < SIZE_Y);
    end

    always_ff @(posedge clock) begin
        if (accept && !reset) begin
            snap_heli_x <= heli_x;
            snap_heli_y <= heli_y;
            snap_en     <= obj_en;
            for (int i = 0; i < NUM_OBJ; i++) begin
                snap_obj_x[i] <= obj_x[i*XW +: XW];
                snap_obj_y[i] <= obj_y[i*YW +: YW];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            collision <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            collision <= 1'b0;
        end else if (state == CHECK) begin
            if (overlap) begin
                collision <= 1'b1;
            end else if (!last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (check) state_next = CHECK;
            CHECK:   if (overlap || last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == CHECK);
        done_check = (state == DONE);
    end

endmodule
